// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter transmitter.
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StMark,
    StGap,
    StLgap
  } state_e;

  localparam int unsigned LETTER_MAX = 25;
  localparam int unsigned DOT_UNITS  = 1;
  localparam int unsigned DASH_UNITS = 3;
  localparam int unsigned LGAP_UNITS = 3;

  // pat bit i is element i, LSB first; 1 = dash, 0 = dot.
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [3:0] pat;
  } code_t;

endpackage

// File: rtl/morse_lut.sv
// Letter index (0 = A .. 25 = Z) to Morse element count and dot/dash pattern.
module morse_lut
  import morse_pkg::*;
(
  input  logic [4:0] letter,
  output code_t      code
);

  logic [6:0] len_pat;

  always_comb begin
    len_pat = 7'd0;
    case (letter)
      5'd0:  len_pat = {3'd2, 4'b0010}; // A .-
      5'd1:  len_pat = {3'd4, 4'b0001}; // B -...
      5'd2:  len_pat = {3'd4, 4'b0101}; // C -.-.
      5'd3:  len_pat = {3'd3, 4'b0001}; // D -..
      5'd4:  len_pat = {3'd1, 4'b0000}; // E .
      5'd5:  len_pat = {3'd4, 4'b0100}; // F ..-.
      5'd6:  len_pat = {3'd3, 4'b0011}; // G --.
      5'd7:  len_pat = {3'd4, 4'b0000}; // H ....
      5'd8:  len_pat = {3'd2, 4'b0000}; // I ..
      5'd9:  len_pat = {3'd4, 4'b1110}; // J .---
      5'd10: len_pat = {3'd3, 4'b0101}; // K -.-
      5'd11: len_pat = {3'd4, 4'b0010}; // L .-..
      5'd12: len_pat = {3'd2, 4'b0011}; // M --
      5'd13: len_pat = {3'd2, 4'b0001}; // N -.
      5'd14: len_pat = {3'd3, 4'b0111}; // O ---
      5'd15: len_pat = {3'd4, 4'b0110}; // P .--.
      5'd16: len_pat = {3'd4, 4'b1011}; // Q --.-
      5'd17: len_pat = {3'd3, 4'b0010}; // R .-.
      5'd18: len_pat = {3'd3, 4'b0000}; // S ...
      5'd19: len_pat = {3'd1, 4'b0001}; // T -
      5'd20: len_pat = {3'd3, 4'b0100}; // U ..-
      5'd21: len_pat = {3'd4, 4'b1000}; // V ...-
      5'd22: len_pat = {3'd3, 4'b0110}; // W .--
      5'd23: len_pat = {3'd4, 4'b1001}; // X -..-
      5'd24: len_pat = {3'd4, 4'b1101}; // Y -.--
      5'd25: len_pat = {3'd4, 4'b0011}; // Z --..
      default: len_pat = 7'd0;
    endcase
  end

  assign code.valid = (letter <= 5'(LETTER_MAX));
  assign code.len   = len_pat[6:4];
  assign code.pat   = len_pat[3:0];

endmodule

// File: rtl/morse_transmitter.sv
// Sends one latched letter as Morse marks timed by the unit tick, then a 3-unit letter gap.
module morse_transmitter
  import morse_pkg::*;
(
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick,
  input  logic [4:0] letter,
  input  logic       start,
  output logic       signal_out,
  output logic       busy,
  output logic       done
);

  state_e     state_q, state_d;
  logic [2:0] len_q, len_d;
  logic [3:0] pat_q, pat_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] cnt_q, cnt_d;
  logic       done_d;
  code_t      code;
  logic [1:0] mark_last;
  logic       last_el;

  morse_lut u_lut (
    .letter (letter),
    .code   (code)
  );

  assign mark_last = pat_q[idx_q] ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
  assign last_el   = ({1'b0, idx_q} == (len_q - 3'd1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // Ticks are ignored here, so a tick coincident with acceptance never counts.
        if (start && code.valid) begin
          len_d   = code.len;
          pat_d   = code.pat;
          idx_d   = 2'd0;
          cnt_d   = 2'd0;
          state_d = StArm;
        end
      end
      StArm: begin
        if (tick) begin
          cnt_d   = 2'd0;
          state_d = StMark;
        end
      end
      StMark: begin
        if (tick) begin
          if (cnt_q == mark_last) begin
            cnt_d   = 2'd0;
            state_d = last_el ? StLgap : StGap;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      StGap: begin
        if (tick) begin
          idx_d   = idx_q + 2'd1;
          state_d = StMark;
        end
      end
      StLgap: begin
        if (tick) begin
          if (cnt_q == 2'(LGAP_UNITS - 1)) begin
            cnt_d   = 2'd0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= 3'd0;
      pat_q      <= 4'd0;
      idx_q      <= 2'd0;
      cnt_q      <= 2'd0;
      signal_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pat_q      <= pat_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      signal_out <= (state_d == StMark);
      busy       <= (state_d != StIdle);
      done       <= done_d;
    end
  end

endmodule
